// File: rtl/instr_fetch.sv
// Instruction fetch unit: four-state fetch/execute sequencer with a byte-wide
// instruction memory handshake, branch PC arithmetic and a saturating retire count.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [7:0]        imem_data_i,
    output logic [7:0]        instruction_o,
    output logic              instr_valid_o,
    input  logic              stall_i,
    input  logic              branchf_i,
    input  logic              branchb_i,
    input  logic [ADDR_W-1:0] branch_offset_i,
    input  logic              done_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o,
    output logic [15:0]       instr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_nxt_s;
    logic [15:0]       cnt_inc_s;
    logic [7:0]        instr_r;
    logic [7:0]        instr_nxt_s;
    logic              req_r;
    logic              valid_r;
    logic              halted_r;

    // Saturating increment of the retired-instruction count.
    always_comb begin
        if (cnt_r == 16'hFFFF) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 16'd1;
        end
    end

    // Next-state, PC, count and instruction selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        instr_nxt_s = instr_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = start_addr_i;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    state_nxt_s = ST_EXEC;
                    instr_nxt_s = imem_data_i;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!stall_i) begin
                    cnt_nxt_s = cnt_inc_s;
                    // done_i outranks both branch requests; PC arithmetic wraps naturally.
                    if (done_i) begin
                        state_nxt_s = ST_HALT;
                    end else if (branchf_i) begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = pc_r + branch_offset_i;
                    end else if (branchb_i) begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = pc_r - branch_offset_i;
                    end else begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = pc_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are decoded from the next state
    // so every output comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            cnt_r    <= 16'd0;
            instr_r  <= 8'h00;
            req_r    <= 1'b0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            cnt_r    <= cnt_nxt_s;
            instr_r  <= instr_nxt_s;
            req_r    <= (state_nxt_s == ST_FETCH);
            valid_r  <= (state_nxt_s == ST_EXEC);
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = pc_r;
    assign pc_o          = pc_r;
    assign instruction_o = instr_r;
    assign instr_valid_o = valid_r;
    assign halted_o      = halted_r;
    assign instr_count_o = cnt_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue holds expected fetch
// addresses, pushed when a start/exec decision is driven and popped at each fetch.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [7:0]  start_addr_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i;
    logic [7:0]  imem_data_i;
    logic [7:0]  instruction_o;
    logic        instr_valid_o;
    logic        stall_i;
    logic        branchf_i;
    logic        branchb_i;
    logic [7:0]  branch_offset_i;
    logic        done_i;
    logic [7:0]  pc_o;
    logic        halted_o;
    logic [15:0] instr_count_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fetch_cyc = 0;
    int          c0 = 0;
    logic [7:0]  model_pc;
    logic [15:0] model_cnt;
    logic [7:0]  model_instr;
    logic [7:0]  exp_q[$];

    instr_fetch dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .start_addr_i(start_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_data_i(imem_data_i), .instruction_o(instruction_o), .instr_valid_o(instr_valid_o),
        .stall_i(stall_i), .branchf_i(branchf_i), .branchb_i(branchb_i),
        .branch_offset_i(branch_offset_i), .done_i(done_i), .pc_o(pc_o),
        .halted_o(halted_o), .instr_count_o(instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic do_start(input logic [7:0] a);
        start_i      = 1'b1;
        start_addr_i = a;
        model_pc     = a;
        model_cnt    = 16'd0;
        exp_q.push_back(a);
        step();
        start_i      = 1'b0;
        start_addr_i = 8'h00;
    endtask

    // Called at the first negedge of a fetch; acks after wait_n cycles.
    task automatic do_fetch(input int wait_n, input bit noise);
        logic [7:0] a;
        fetch_cyc = cyc;
        chk("fetch_req", imem_req_o, 1);
        chk("fetch_valid_low", instr_valid_o, 0);
        chk("fetch_count", instr_count_o, model_cnt);
        chk("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) a = exp_q.pop_front();
        else a = 8'hxx;
        chk("fetch_addr", imem_addr_o, a);
        chk("fetch_pc", pc_o, a);
        for (int i = 0; i < wait_n; i++) begin
            if (noise) begin
                start_i = 1'b1; start_addr_i = 8'h77; done_i = 1'b1; branchf_i = 1'b1;
            end
            step();
            chk("addr_stable", imem_addr_o, a);
            chk("req_held", imem_req_o, 1);
        end
        start_i = 1'b0; start_addr_i = 8'h00; done_i = 1'b0; branchf_i = 1'b0;
        imem_ack_i  = 1'b1;
        imem_data_i = mem_byte(a);
        model_instr = mem_byte(a);
        step();
        imem_ack_i  = 1'b0;
        imem_data_i = 8'h00;
        chk("exec_valid", instr_valid_o, 1);
        chk("exec_instr", instruction_o, model_instr);
        chk("exec_req_low", imem_req_o, 0);
    endtask

    // Called at the first negedge of EXEC; stalls stall_n cycles with requests visible.
    task automatic do_exec(input int stall_n, input bit done, input bit bf, input bit bb,
                           input logic [7:0] off);
        int vcyc = 0;
        for (int i = 0; i < stall_n; i++) begin
            vcyc += int'(instr_valid_o);
            stall_i = 1'b1; done_i = done; branchf_i = bf; branchb_i = bb; branch_offset_i = off;
            step();
            chk("stall_instr_hold", instruction_o, model_instr);
            chk("stall_pc_hold", pc_o, model_pc);
            chk("stall_count_hold", instr_count_o, model_cnt);
        end
        vcyc += int'(instr_valid_o);
        chk("valid_cycles", vcyc, stall_n + 1);
        stall_i = 1'b0; done_i = done; branchf_i = bf; branchb_i = bb; branch_offset_i = off;
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        if (!done) begin
            if (bf) model_pc = model_pc + off;
            else if (bb) model_pc = model_pc - off;
            else model_pc = model_pc + 8'd1;
            exp_q.push_back(model_pc);
        end
        step();
        done_i = 1'b0; branchf_i = 1'b0; branchb_i = 1'b0; branch_offset_i = 8'h00;
        chk("post_exec_valid_low", instr_valid_o, 0);
        if (done) begin
            chk("halt_flag", halted_o, 1);
            chk("halt_req_low", imem_req_o, 0);
            chk("halt_pc", pc_o, model_pc);
            chk("halt_count", instr_count_o, model_cnt);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req_o, 0);
        chk({tag, "_valid"}, instr_valid_o, 0);
        chk({tag, "_halted"}, halted_o, 0);
        chk({tag, "_instr"}, instruction_o, 8'h00);
        chk({tag, "_pc"}, pc_o, 8'h00);
        chk({tag, "_count"}, instr_count_o, 16'h0000);
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; start_addr_i = 8'h00; imem_ack_i = 1'b0;
        imem_data_i = 8'h00; stall_i = 1'b0; branchf_i = 1'b0; branchb_i = 1'b0;
        branch_offset_i = 8'h00; done_i = 1'b0;
        model_pc = 8'h00; model_cnt = 16'd0; model_instr = 8'h00;
        #2;
        chk_reset_vals("por");
        step();
        rst_n_i = 1'b1;
        step();
        step();
        chk_reset_vals("idle_after_release");

        // Sequential run from 0x10 with 1-cycle acks.
        do_start(8'h10);
        do_fetch(1, 1'b0);
        c0 = fetch_cyc;
        do_exec(0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_fetch(1, 1'b0);
        chk("spacing_1", fetch_cyc - c0, 3);
        c0 = fetch_cyc;
        do_exec(0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_fetch(1, 1'b0);
        chk("spacing_2", fetch_cyc - c0, 3);
        do_exec(0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_fetch(1, 1'b0);
        chk("count_after_three", instr_count_o, 16'd3);
        do_exec(0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Forward branch, then backward branch that wraps.
        do_start(8'h20);
        do_fetch(1, 1'b0);
        do_exec(0, 1'b0, 1'b1, 1'b0, 8'h05);
        do_fetch(1, 1'b0);
        chk("bf_addr", imem_addr_o, 8'h25);
        do_exec(0, 1'b0, 1'b0, 1'b1, 8'h30);
        do_fetch(1, 1'b0);
        chk("bb_wrap_addr", imem_addr_o, 8'hF5);

        // All requests together: done wins; HALT ignores ack and branch requests.
        do_exec(0, 1'b1, 1'b1, 1'b1, 8'h40);
        imem_ack_i = 1'b1; imem_data_i = 8'h3C; branchf_i = 1'b1; done_i = 1'b1;
        branch_offset_i = 8'h11;
        step();
        step();
        imem_ack_i = 1'b0; imem_data_i = 8'h00; branchf_i = 1'b0; done_i = 1'b0;
        branch_offset_i = 8'h00;
        chk("halt_pc_held", pc_o, 8'hF5);
        chk("halt_still", halted_o, 1);
        chk("halt_instr_held", instruction_o, model_instr);
        chk("halt_valid_low", instr_valid_o, 0);

        // Restart at 0x00: 5-cycle ack with start/done noise, then 2 stall cycles.
        do_start(8'h00);
        chk("restart_count_clear", instr_count_o, 16'd0);
        chk("restart_not_halted", halted_o, 0);
        do_fetch(5, 1'b1);
        do_exec(2, 1'b0, 1'b0, 1'b0, 8'h00);
        do_fetch(1, 1'b0);
        chk("one_pc_update", imem_addr_o, 8'h01);
        do_exec(0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset pulse during an outstanding fetch, followed by a late ack.
        chk("pre_reset_req", imem_req_o, 1);
        chk("pre_reset_addr", imem_addr_o, 8'h02);
        exp_q.delete();
        #1 rst_n_i = 1'b0;
        #1 chk_reset_vals("async_rst");
        #1 rst_n_i = 1'b1;
        imem_ack_i = 1'b1; imem_data_i = 8'hEE;
        step();
        imem_ack_i = 1'b0; imem_data_i = 8'h00;
        step();
        chk_reset_vals("late_ack");
        model_pc = 8'h00; model_cnt = 16'd0;

        // Count near saturation while the PC runs through 0xFF.
        do_start(8'hFC);
        do_fetch(1, 1'b0);
        force dut.cnt_r = 16'hFFFD;
        #1 release dut.cnt_r;
        model_cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            do_exec(0, 1'b0, 1'b0, 1'b0, 8'h00);
            do_fetch(1, 1'b0);
        end
        chk("pc_wrap", pc_o, 8'h00);
        chk("count_sat", instr_count_o, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
